// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   - tx_state_e : serializer FSM states
//   - DATA_BITS / STOP_BITS : frame shape constants
//   - baud_div() : clock cycles per bit time (truncating division)
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 8E1).
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO with registered level/full flags.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_wr, i_data        write strobe and byte; dropped while full
//   i_rd                pop request; ignored while empty
//   o_data              head-of-queue byte (combinational read)
//   o_empty, o_full     occupancy flags (o_full registered)
//   o_level             registered occupancy count
//   o_overflow          sticky, set by any write attempted while full
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr,
    input  logic [7:0]               i_data,
    input  logic                     i_rd,
    output logic [7:0]               o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [7:0]      r_mem [DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [LvlW-1:0] r_level;
    logic            r_full;
    logic            r_overflow;

    logic            w_push;
    logic            w_pop;
    logic [LvlW-1:0] w_level_d;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign w_push = i_wr && !r_full;
    assign w_pop  = i_rd && (r_level != '0);

    always_comb begin
        w_level_d = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_d = r_level + 1'b1;
            2'b01:   w_level_d = r_level - 1'b1;
            default: w_level_d = r_level;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_d;
            r_full  <= (w_level_d == LvlW'(DEPTH));
            if (i_wr && r_full) r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_empty    = (r_level == '0);
    assign o_full     = r_full;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_buf_tx.sv
// uart_buf_tx: buffered UART transmitter. Bytes written on tx_wr_i are queued
// in a FIFO and shifted out LSB first as 8N1 frames (8E1 when UART_TX_PARITY_EN
// is defined). Back-to-back frames are contiguous.
// Ports:
//   clk_i, rst      clock, synchronous active-high reset
//   tx_data_i       byte to enqueue, sampled when tx_wr_i is high
//   tx_wr_i         write strobe
//   tx_full_o       FIFO full (registered)
//   fifo_level_o    FIFO occupancy (registered)
//   overflow_o      sticky dropped-write flag
//   uart_tx_o       serial line, idle high, registered
//   uart_tx_busy    high while a frame is on the line
module uart_buf_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_wr_i,
    output logic                          tx_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          uart_tx_o,
    output logic                          uart_tx_busy
);

    localparam int unsigned BaudDiv = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned CntW    = $clog2(BaudDiv);

    tx_state_e       r_state;
    tx_state_e       w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_busy;

    logic            w_tick;
    logic            w_last_bit;
    logic            w_pop;
    logic            w_empty;
    logic [7:0]      w_head;
    logic            w_tx_d;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk_i),
        .i_rst      (rst),
        .i_wr       (tx_wr_i),
        .i_data     (tx_data_i),
        .i_rd       (w_pop),
        .o_data     (w_head),
        .o_empty    (w_empty),
        .o_full     (tx_full_o),
        .o_level    (fifo_level_o),
        .o_overflow (overflow_o)
    );

    assign w_tick     = (r_cnt == CntW'(BaudDiv - 1));
    assign w_last_bit = (r_bit == 3'(DATA_BITS - 1));

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_tick) w_state_d = StData;
            end
            StData: begin
                if (w_tick && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                    w_state_d = StParity;
`else
                    w_state_d = StStop;
`endif
                end
            end
            StParity: begin
                if (w_tick) w_state_d = StStop;
            end
            StStop: begin
                // Reload straight into START so queued frames abut with no gap.
                if (w_tick) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= ^w_head;
        end
    end
`endif

    // Line level for the current state; registered below so uart_tx_o is glitch-free.
    always_comb begin
        w_tx_d = 1'b1;
        case (r_state)
            StStart:  w_tx_d = 1'b0;
            StData:   w_tx_d = r_shift[0];
`ifdef UART_TX_PARITY_EN
            StParity: w_tx_d = r_par;
`endif
            default:  w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_tx    <= w_tx_d;
            r_busy  <= (r_state != StIdle);
            if (r_state == StIdle || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_pop) begin
                r_shift <= w_head;
                r_bit   <= '0;
            end else if (r_state == StData && w_tick) begin
                r_shift <= r_shift >> 1;
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

    assign uart_tx_o    = r_tx;
    assign uart_tx_busy = r_busy;

endmodule

// File: tb/tb_uart_buf_tx.sv
// Bench for uart_buf_tx: table of single-byte frames checked cycle by cycle,
// hand sequences for burst/overflow/reset, and a random stream checked by a
// line decoder against a queue of written bytes.
module tb_uart_buf_tx;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned BD       = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * BD;

    logic       clk_i = 1'b0;
    logic       rst;
    logic [7:0] tx_data_i;
    logic       tx_wr_i;
    logic       tx_full_o;
    logic [2:0] fifo_level_o;
    logic       overflow_o;
    logic       uart_tx_o;
    logic       uart_tx_busy;

    uart_buf_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .tx_data_i    (tx_data_i),
        .tx_wr_i      (tx_wr_i),
        .tx_full_o    (tx_full_o),
        .fifo_level_o (fifo_level_o),
        .overflow_o   (overflow_o),
        .uart_tx_o    (uart_tx_o),
        .uart_tx_busy (uart_tx_busy)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    longint cyc = 0;

    initial forever begin
        @(posedge clk_i);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=timeout required=done", name);
    endtask

    // Line decoder: samples mid-bit on the falling clock edge.
    logic [7:0] rx_q[$];
    longint     start_q[$];
    bit         mon_busy = 0;
    int         mon_cnt;
    int         mon_k;
    logic [7:0] mon_byte;

    initial forever begin
        @(negedge clk_i);
        if (rst === 1'b1) begin
            mon_busy = 0;
        end else if (!mon_busy) begin
            if (uart_tx_o === 1'b0) begin
                mon_busy = 1;
                mon_cnt  = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
        end
        if (mon_busy && (mon_cnt % BD) == BD / 2) begin
            mon_k = mon_cnt / BD;
            if (mon_k == 0) begin
                chk("mon_start_bit", uart_tx_o, 1'b0);
            end else if (mon_k <= 8) begin
                mon_byte[mon_k-1] = uart_tx_o;
            end else if (mon_k < NBITS - 1) begin
                chk("mon_parity_bit", uart_tx_o, ^mon_byte);
            end else begin
                chk("mon_stop_bit", uart_tx_o, 1'b1);
                rx_q.push_back(mon_byte);
                mon_busy = 0;
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // {stop, data[7:0], start}
        logic       par;
    } vec_t;

    vec_t vt[6];

    function automatic logic exp_bit(input vec_t v, input int b);
        if (b < 9) return v.bits[b];
        else if (b == NBITS - 1) return v.bits[9];
        else return v.par;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write1(input logic [7:0] d);
        tx_data_i = d;
        tx_wr_i   = 1'b1;
        step();
        tx_wr_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int quiet;
        quiet = 0;
        for (int t = 0; t < limit; t++) begin
            step();
            if (!uart_tx_busy && fifo_level_o == 3'd0 && !mon_busy) quiet++;
            else quiet = 0;
            if (quiet >= 3) return;
        end
        fail(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        logic got;
        logic exp;
        int   busy_cnt;
        int   lows;
        bit   seen;
        int   nw;
        int   gap;
        int   guard;
        logic [7:0] exp_q[$];
        logic [7:0] d;

        vt[0] = '{8'hA5, 10'b1101001010, 1'b0};
        vt[1] = '{8'h00, 10'b1000000000, 1'b0};
        vt[2] = '{8'hFF, 10'b1111111110, 1'b0};
        vt[3] = '{8'h3C, 10'b1001111000, 1'b0};
        vt[4] = '{8'h07, 10'b1000001110, 1'b1};
        vt[5] = '{8'h03, 10'b1000000110, 1'b0};

        rst = 1'b1;
        tx_wr_i = 1'b0;
        tx_data_i = 8'h00;
        repeat (3) step();
        chk("rst_line", uart_tx_o, 1'b1);
        chk("rst_busy", uart_tx_busy, 1'b0);
        chk("rst_full", tx_full_o, 1'b0);
        chk("rst_level", fifo_level_o, 3'd0);
        chk("rst_overflow", overflow_o, 1'b0);
        rst = 1'b0;
        repeat (2) step();

        // Single frames, every cycle of every bit cell checked.
        for (int i = 0; i < 6; i++) begin
            rx_q.delete();
            write1(vt[i].data);
            chk($sformatf("vec%0d_level_after_write", i), fifo_level_o, 3'd1);
            step();
            chk($sformatf("vec%0d_line_before_start", i), uart_tx_o, 1'b1);
            chk($sformatf("vec%0d_busy_before_start", i), uart_tx_busy, 1'b0);
            busy_cnt = 0;
            for (int b = 0; b < NBITS; b++) begin
                exp = exp_bit(vt[i], b);
                got = exp;
                for (int c = 0; c < BD; c++) begin
                    step();
                    if (uart_tx_o !== exp) got = uart_tx_o;
                    if (uart_tx_busy === 1'b1) busy_cnt++;
                end
                chk($sformatf("vec%0d_bit%0d", i, b), got, exp);
            end
            chk($sformatf("vec%0d_busy_cycles", i), busy_cnt, FRAME);
            step();
            chk($sformatf("vec%0d_busy_end", i), uart_tx_busy, 1'b0);
            chk($sformatf("vec%0d_line_end", i), uart_tx_o, 1'b1);
            chk($sformatf("vec%0d_rx_count", i), rx_q.size(), 1);
            if (rx_q.size() > 0) chk($sformatf("vec%0d_rx_byte", i), rx_q[0], vt[i].data);
            repeat (3) step();
        end

        // Burst of three consecutive writes: contiguous frames.
        rx_q.delete();
        start_q.delete();
        tx_wr_i = 1'b1;
        tx_data_i = 8'h00;
        step();
        chk("burst_level_first", fifo_level_o, 3'd1);
        tx_data_i = 8'hFF;
        step();
        tx_data_i = 8'h55;
        step();
        tx_wr_i = 1'b0;
        chk("burst_level_third", fifo_level_o, 3'd2);
        busy_cnt = 0;
        seen = 0;
        for (int t = 0; t < 6 * FRAME; t++) begin
            if (uart_tx_busy === 1'b1) begin
                seen = 1;
                busy_cnt++;
            end else if (seen) begin
                break;
            end
            step();
        end
        chk("burst_busy_contiguous", busy_cnt, 3 * FRAME);
        wait_drain("burst_drain", 4 * FRAME);
        chk("burst_level_drained", fifo_level_o, 3'd0);
        chk("burst_rx_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("burst_rx0", rx_q[0], 8'h00);
            chk("burst_rx1", rx_q[1], 8'hFF);
            chk("burst_rx2", rx_q[2], 8'h55);
        end
        if (start_q.size() == 3) begin
            chk("burst_gap01", 32'(start_q[1] - start_q[0]), FRAME);
            chk("burst_gap12", 32'(start_q[2] - start_q[1]), FRAME);
        end else begin
            chk("burst_start_count", start_q.size(), 3);
        end

        // Overflow: six writes into a four-deep FIFO while idle.
        rx_q.delete();
        tx_wr_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tx_data_i = 8'(k);
            step();
        end
        tx_wr_i = 1'b0;
        chk("ovf_full", tx_full_o, 1'b1);
        chk("ovf_flag", overflow_o, 1'b1);
        chk("ovf_level", fifo_level_o, 3'd4);
        wait_drain("ovf_drain", 7 * FRAME);
        chk("ovf_rx_count", rx_q.size(), 5);
        for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
            chk($sformatf("ovf_rx%0d", k), rx_q[k], 8'(k + 1));
        end
        chk("ovf_sticky", overflow_o, 1'b1);
        chk("ovf_full_cleared", tx_full_o, 1'b0);
        do_reset();
        chk("ovf_cleared_by_reset", overflow_o, 1'b0);

        // Reset 35 cycles into a frame with a second byte still queued.
        rx_q.delete();
        tx_wr_i = 1'b1;
        tx_data_i = 8'h81;
        step();
        tx_data_i = 8'h42;
        step();
        tx_wr_i = 1'b0;
        guard = 0;
        while (uart_tx_o !== 1'b0 && guard < 10) begin
            step();
            guard++;
        end
        if (guard >= 10) fail("midrst_start_seen");
        repeat (35) step();
        rst = 1'b1;
        step();
        chk("midrst_line", uart_tx_o, 1'b1);
        chk("midrst_busy", uart_tx_busy, 1'b0);
        chk("midrst_level", fifo_level_o, 3'd0);
        chk("midrst_overflow", overflow_o, 1'b0);
        rst = 1'b0;
        lows = 0;
        busy_cnt = 0;
        for (int t = 0; t < 3 * FRAME; t++) begin
            step();
            if (uart_tx_o !== 1'b1) lows++;
            if (uart_tx_busy !== 1'b0) busy_cnt++;
        end
        chk("midrst_no_low_after", lows, 0);
        chk("midrst_no_busy_after", busy_cnt, 0);
        chk("midrst_no_frames", rx_q.size(), 0);

        // Random stream; outstanding bytes kept below FIFO capacity.
        rx_q.delete();
        exp_q.delete();
        nw = 0;
        for (int i = 0; i < 24; i++) begin
            guard = 0;
            while ((nw - rx_q.size()) >= 4 && guard < 3 * FRAME) begin
                step();
                guard++;
            end
            if (guard >= 3 * FRAME) fail("rand_backpressure_wait");
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 2 * FRAME);
            repeat (gap) step();
            d = 8'($urandom);
            exp_q.push_back(d);
            write1(d);
            nw++;
        end
        wait_drain("rand_drain", 8 * FRAME);
        chk("rand_rx_count", rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            chk($sformatf("rand_rx%0d", k), rx_q[k], exp_q[k]);
        end
        chk("rand_no_overflow", overflow_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
